demux_seq1_2: RTL and testbench
===============================

// Module: demux_seq1_2
// PURPOSE
//   Buffered 1-to-2 demultiplexer. It is the distribution counterpart of mux_comb2_1.
//   - Accepts one DATA_WIDTH word per cycle from a single source.
//   - Steers the word to the low branch, the high branch or both (multicast), as i_cmd selects.
//   - Buffers each branch in its own FIFO, with valid/ready on every side.
//   - Used at NoC tree fan-out nodes, where downstream leaves stall independently.
// PARAMETERS
//   DATA_WIDTH  32  width of one data word
//   FIFO_DEPTH  4   entries per branch FIFO; power of two, >= 2
// PORTS
//   clk          input   1             clock; all state updates on rising edge
//   rst_n        input   1             reset; synchronous, active-low
//   i_valid      input   1             input word valid
//   i_data_bus   input   DATA_WIDTH    input word
//   o_ready      output  1             block can accept the word this cycle
//   i_en         input   1             demux enable
//   i_cmd        input   2             01=low, 10=high, 11=both, 00=drop
//   o_valid      output  2             [0]=low branch valid, [1]=high branch valid
//   o_data_bus   output  2*DATA_WIDTH  [0+:DW]=low branch head, [DW+:DW]=high branch head
//   i_ready      input   2             downstream ready, per branch
// BEHAVIOUR
//   Reset
//   - When rst_n=0 at a rising edge: both FIFO read/write pointers and counts clear.
//   - o_valid=2'b00 and o_data_bus=0 from the following cycle.
//   - Reset mid-operation discards all buffered words, with no partial outputs.
//   Input handshake
//   - full_b = (count_b == FIFO_DEPTH).
//   - o_ready is combinational: o_ready = i_en & ~(i_cmd[0] & full_lo) & ~(i_cmd[1] & full_hi).
//   - i_cmd=00 gives o_ready=i_en.
//   - accept = i_valid & o_ready.
//   - On accept the word is written to every FIFO whose i_cmd bit is set.
//   - On accept with cmd 00 the word is consumed and discarded.
//   - Multicast is atomic: the word is taken only when both FIFOs have space, and never enters just one.
//   - i_en=0: o_ready=0 and nothing is accepted. Buffered words keep draining; outputs are never tri-stated.
//   - i_cmd is sampled only in the accept cycle.
//   Output handshake, per branch b
//   - o_valid[b] = (count_b != 0).
//   - o_data_bus slice b = FIFO_b head when valid, else 0.
//   - pop_b = o_valid[b] & i_ready[b]. The read pointer advances and the next entry appears in the next cycle.
//   - Once o_valid[b] is asserted, the data is held stable until popped.
//   - The branches are fully independent: a stall on one never blocks pops on the other.
//   - A stall on one branch blocks input only for cmds that target it.
//   Latency and throughput
//   - An accepted word is visible at the output one cycle after accept (registered storage, no bypass).
//   - Sustained throughput is 1 word/cycle per branch when downstream is always ready.
//   Boundary conditions
//   - Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance.
//   - Full FIFO plus a pop in the same cycle: o_ready still 0 that cycle (computed from registered count), so there is no fall-through.
//   - Empty FIFO plus a push: no same-cycle output; o_valid rises the next cycle.
//   - Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
//   - The count is log2(FIFO_DEPTH)+1 bits wide and ranges 0..FIFO_DEPTH; it never over- or underflows.
//   - i_ready[b]=1 while o_valid[b]=0 has no effect.
// TESTING
//   1. Reset: hold rst_n=0 for 2 cycles with i_valid=1.
//      -> o_valid=00, o_data_bus=0, no words stored after release.
//   2. Unicast: send 0xA5A5_0001 with cmd 01, then 0xA5A5_0002 with cmd 10, i_ready=11.
//      -> low branch shows 0x..01 one cycle after its accept.
//      -> high branch shows 0x..02 one cycle after its accept.
//   3. Multicast backpressure: i_ready=01, send 5 words with cmd 11 (DEPTH=4).
//      -> o_ready=0 on the 5th word.
//      -> after the high FIFO fills, no further multicast is accepted even though the low branch drains.
//      -> both branches eventually output the same 4 words in order.
//   4. Full plus pop: fill the low FIFO, then set i_ready[0]=1 and present a cmd-01 word in the same cycle.
//      -> not accepted that cycle; accepted the next cycle; count returns to 4.
//   5. Enable and drop: i_en=0 with 2 words buffered.
//      -> o_ready=0 and both words drain.
//      -> then with i_en=1, a cmd-00 word is accepted and never appears on o_valid.
//   6. Random: random i_valid, i_cmd and i_ready for 10k cycles against a scoreboard.
//      -> per-branch ordered, lossless delivery.
//      -> data stays stable while o_valid=1 and not popped.

Source files
------------

// File: rtl/demux_seq1_2.sv
// Buffered 1-to-2 demultiplexer with one FIFO per output branch.
// Words go low, high, both (atomic multicast) or are dropped, per i_cmd.

module demux_seq1_2_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_push,
   input  logic [DATA_WIDTH-1:0]         i_data,
   input  logic                          i_pop,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_valid,
   output logic [DATA_WIDTH-1:0]         o_data
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [AW:0]           r_count;
   logic [DATA_WIDTH-1:0] w_head;

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (i_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   // Occupancy; push and pop together leave it unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         unique case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head is forced to zero when empty so stale entries never leak out.
   always_comb begin
      w_head  = r_mem[r_rptr];
      o_valid = (r_count != '0);
      o_data  = o_valid ? w_head : '0;
      o_count = r_count;
   end

endmodule

module demux_seq1_2 #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   input  logic [DATA_WIDTH-1:0]   i_data_bus,
   output logic                    o_ready,
   input  logic                    i_en,
   input  logic [1:0]              i_cmd,
   output logic [1:0]              o_valid,
   output logic [2*DATA_WIDTH-1:0] o_data_bus,
   input  logic [1:0]              i_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LP_FULL = FIFO_DEPTH[AW:0];

   logic [AW:0]           w_cnt_lo;
   logic [AW:0]           w_cnt_hi;
   logic                  w_full_lo;
   logic                  w_full_hi;
   logic                  w_accept;
   logic                  w_push_lo;
   logic                  w_push_hi;
   logic                  w_pop_lo;
   logic                  w_pop_hi;
   logic                  w_vld_lo;
   logic                  w_vld_hi;
   logic [DATA_WIDTH-1:0] w_dat_lo;
   logic [DATA_WIDTH-1:0] w_dat_hi;

   // Input side: readiness comes from registered counts only, so a pop
   // on a full branch cannot fall through to a push in the same cycle.
   always_comb begin
      w_full_lo = (w_cnt_lo == LP_FULL);
      w_full_hi = (w_cnt_hi == LP_FULL);
      o_ready   = i_en
                & ~(i_cmd[0] & w_full_lo)
                & ~(i_cmd[1] & w_full_hi);
      w_accept  = i_valid & o_ready;
      w_push_lo = w_accept & i_cmd[0];
      w_push_hi = w_accept & i_cmd[1];
   end

   // Output side: each branch pops independently of the other.
   always_comb begin
      w_pop_lo   = w_vld_lo & i_ready[0];
      w_pop_hi   = w_vld_hi & i_ready[1];
      o_valid    = {w_vld_hi, w_vld_lo};
      o_data_bus = {w_dat_hi, w_dat_lo};
   end

   demux_seq1_2_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo_lo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_lo),
      .i_data  (i_data_bus),
      .i_pop   (w_pop_lo),
      .o_count (w_cnt_lo),
      .o_valid (w_vld_lo),
      .o_data  (w_dat_lo)
   );

   demux_seq1_2_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo_hi (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_hi),
      .i_data  (i_data_bus),
      .i_pop   (w_pop_hi),
      .o_count (w_cnt_hi),
      .o_valid (w_vld_hi),
      .o_data  (w_dat_hi)
   );

endmodule

// File: tb/tb_demux_seq1_2.sv
// Bench for demux_seq1_2: directed cases then random traffic,
// with per-branch expected-word queues drained by a monitor.

module tb_demux_seq1_2;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            i_valid;
   logic [DW-1:0]   i_data_bus;
   logic            o_ready;
   logic            i_en;
   logic [1:0]      i_cmd;
   logic [1:0]      o_valid;
   logic [2*DW-1:0] o_data_bus;
   logic [1:0]      i_ready;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt_lo  = 0;
   int cnt_hi  = 0;
   logic [DW-1:0] q_lo [$];
   logic [DW-1:0] q_hi [$];

   demux_seq1_2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .i_data_bus (i_data_bus),
      .o_ready    (o_ready),
      .i_en       (i_en),
      .i_cmd      (i_cmd),
      .o_valid    (o_valid),
      .o_data_bus (o_data_bus),
      .i_ready    (i_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One cycle of stimulus; the occupancy model decides readiness.
   task automatic step(input logic v, input logic [DW-1:0] d,
                       input logic [1:0] c, input logic e,
                       input logic [1:0] r, output logic acc);
      logic er;
      logic pl;
      logic ph;
      i_valid    = v;
      i_data_bus = d;
      i_cmd      = c;
      i_en       = e;
      i_ready    = r;
      @(negedge clk);
      er = e && !(c[0] && cnt_lo == DEPTH)
             && !(c[1] && cnt_hi == DEPTH);
      chk("o_ready", 64'(o_ready), 64'(er));
      acc = v & er;
      pl  = (cnt_lo != 0) && r[0];
      ph  = (cnt_hi != 0) && r[1];
      @(posedge clk);
      if (acc && c[0]) q_lo.push_back(d);
      if (acc && c[1]) q_hi.push_back(d);
      cnt_lo = cnt_lo + int'(acc && c[0]) - int'(pl);
      cnt_hi = cnt_hi + int'(acc && c[1]) - int'(ph);
      #1;
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      i_valid = 1'b1;
      i_en    = 1'b1;
      i_cmd   = 2'b11;
      repeat (2) begin
         @(posedge clk);
         q_lo.delete();
         q_hi.delete();
         cnt_lo = 0;
         cnt_hi = 0;
      end
      #1;
      rst_n   = 1'b1;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      logic a;
      int   k;
      k = 0;
      while ((cnt_lo != 0 || cnt_hi != 0) && k < 30) begin
         step(1'b0, '0, 2'b00, 1'b1, 2'b11, a);
         k++;
      end
      chk("drain_empty", 64'(cnt_lo + cnt_hi), 64'(0));
   endtask

   // Monitor: compares each branch head against its queue front.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("lo_valid", 64'(o_valid[0]), 64'(q_lo.size() != 0));
         chk("hi_valid", 64'(o_valid[1]), 64'(q_hi.size() != 0));
         if (q_lo.size() != 0) begin
            chk("lo_data", 64'(o_data_bus[0+:DW]), 64'(q_lo[0]));
            if (i_ready[0]) void'(q_lo.pop_front());
         end else begin
            chk("lo_zero", 64'(o_data_bus[0+:DW]), 64'(0));
         end
         if (q_hi.size() != 0) begin
            chk("hi_data", 64'(o_data_bus[DW+:DW]), 64'(q_hi[0]));
            if (i_ready[1]) void'(q_hi.pop_front());
         end else begin
            chk("hi_zero", 64'(o_data_bus[DW+:DW]), 64'(0));
         end
      end
   end

   initial begin
      logic a;
      rst_n      = 1'b0;
      i_valid    = 1'b0;
      i_data_bus = '0;
      i_en       = 1'b0;
      i_cmd      = 2'b00;
      i_ready    = 2'b00;
      @(posedge clk);
      #1;
      apply_reset();
      @(negedge clk);
      chk("rst_valid", 64'(o_valid), 64'(0));
      chk("rst_data", o_data_bus, 64'(0));
      @(posedge clk);
      #1;

      // Unicast to each branch
      step(1'b1, 32'hA5A5_0001, 2'b01, 1'b1, 2'b11, a);
      chk("uni_lo_acc", 64'(a), 64'(1));
      step(1'b1, 32'hA5A5_0002, 2'b10, 1'b1, 2'b11, a);
      chk("uni_hi_acc", 64'(a), 64'(1));
      drain();

      // Multicast backpressure from the stalled high branch
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 32'hB000_0000 + k, 2'b11, 1'b1, 2'b01, a);
         chk("mc_acc", 64'(a), 64'(k < 4));
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 32'hB000_0004, 2'b11, 1'b1, 2'b01, a);
         chk("mc_blocked", 64'(a), 64'(0));
      end
      drain();

      // Full low FIFO with a same-cycle pop: no fall-through
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 32'hC000_0000 + k, 2'b01, 1'b1, 2'b00, a);
         chk("fill_acc", 64'(a), 64'(1));
      end
      step(1'b1, 32'hC000_0004, 2'b01, 1'b1, 2'b01, a);
      chk("full_pop_acc", 64'(a), 64'(0));
      step(1'b1, 32'hC000_0004, 2'b01, 1'b1, 2'b00, a);
      chk("after_pop_acc", 64'(a), 64'(1));
      step(1'b1, 32'hC000_0005, 2'b01, 1'b1, 2'b00, a);
      chk("refull_acc", 64'(a), 64'(0));
      drain();

      // Disable with words buffered, then a dropped word
      step(1'b1, 32'hD000_0001, 2'b01, 1'b1, 2'b00, a);
      step(1'b1, 32'hD000_0002, 2'b10, 1'b1, 2'b00, a);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 32'hD000_0003, 2'b11, 1'b0, 2'b11, a);
         chk("dis_acc", 64'(a), 64'(0));
      end
      chk("dis_drained", 64'(cnt_lo + cnt_hi), 64'(0));
      step(1'b1, 32'hD000_0004, 2'b00, 1'b1, 2'b11, a);
      chk("drop_acc", 64'(a), 64'(1));
      step(1'b0, '0, 2'b00, 1'b1, 2'b11, a);
      step(1'b0, '0, 2'b00, 1'b1, 2'b11, a);

      // Random traffic with one reset in the middle
      for (int k = 0; k < 10000; k++) begin
         if (k == 5000) apply_reset();
         step(($urandom % 4) != 0, $urandom,
              2'($urandom), ($urandom % 8) != 0,
              2'($urandom), a);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
